// File: rtl/systolic_tile_ctrl.sv
// Tile-pass sequencer for an output-stationary ROWS x COLS systolic array.
// Issues the accumulator clear, walks the skewed injection wavefront, waits
// for the array to drain, then raises the tile-result-valid flag.

// One injection lane: valid while the wavefront index covers this lane's
// K-long window, which starts LANE steps late to produce the skew.
module systolic_tile_lane #(
  parameter int LANE = 0,
  parameter int KW   = 9,
  parameter int SW   = 9
) (
  input  logic          i_feed,
  input  logic [SW-1:0] i_t,
  input  logic [KW-1:0] i_k,
  output logic          o_valid
);
  logic [31:0] w_t, w_lo, w_hi;
  assign w_t     = 32'(i_t);
  assign w_lo    = 32'(LANE);
  assign w_hi    = 32'(LANE) + 32'(i_k);
  assign o_valid = i_feed && (w_t >= w_lo) && (w_t < w_hi);
endmodule

module systolic_tile_ctrl #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int K_MAX = 256,
  parameter int KW    = $clog2(K_MAX+1),
  parameter int SW    = $clog2(K_MAX+ROWS+COLS)
) (
  input  logic            clk_i,
  input  logic            rst_async_n_i,
  input  logic            start_i,
  input  logic [KW-1:0]   k_len_i,
  input  logic            feed_stall_i,
  output logic            busy_o,
  output logic            clear_acc_o,
  output logic [ROWS-1:0] row_valid_o,
  output logic [COLS-1:0] col_valid_o,
  output logic [SW-1:0]   step_o,
  output logic            done_o,
  output logic            result_valid_o
);
  localparam int MAXRC   = (ROWS > COLS) ? ROWS : COLS;
  // A 1x1 array has nothing to drain but still spends one cycle in DRAIN.
  localparam int DRAIN_N = (ROWS + COLS - 2 > 0) ? (ROWS + COLS - 2) : 1;
  localparam int DW      = $clog2(DRAIN_N + 1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_DONE} state_t;

  state_t        r_state;
  logic [KW-1:0] r_k;
  logic [SW-1:0] r_t;
  logic [DW-1:0] r_dcnt;
  logic          r_busy, r_clear, r_done, r_result_valid;

  logic [KW-1:0] w_k_clamp;
  logic [SW:0]   w_t_total;   // T = K + max(ROWS,COLS) - 1 feed steps
  logic [SW:0]   w_t_next;
  logic          w_feed;

  assign w_k_clamp = (k_len_i > KW'(K_MAX)) ? KW'(K_MAX) : k_len_i;
  assign w_t_total = (SW+1)'(r_k) + (SW+1)'(MAXRC - 1);
  assign w_t_next  = {1'b0, r_t} + (SW+1)'(1);
  assign w_feed    = (r_state == S_FEED);

  // Pass sequencing; control outputs are registered alongside the state.
  always_ff @(posedge clk_i or negedge rst_async_n_i) begin
    if (!rst_async_n_i) begin
      r_state        <= S_IDLE;
      r_k            <= '0;
      r_t            <= '0;
      r_dcnt         <= '0;
      r_busy         <= 1'b0;
      r_clear        <= 1'b0;
      r_done         <= 1'b0;
      r_result_valid <= 1'b0;
    end else begin
      r_clear <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_k            <= w_k_clamp;
            r_t            <= '0;
            r_result_valid <= 1'b0;
            r_busy         <= 1'b1;
            r_clear        <= 1'b1;
            r_state        <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          r_t    <= '0;
          r_dcnt <= '0;
          if (r_k != '0) begin
            r_state <= S_FEED;
          end else begin
            r_done         <= 1'b1;
            r_result_valid <= 1'b1;
            r_state        <= S_DONE;
          end
        end
        S_FEED: begin
          // The last step keeps t at T-1 so step_o never exceeds its width.
          if (!feed_stall_i) begin
            if (w_t_next == w_t_total) begin
              r_dcnt  <= '0;
              r_state <= S_DRAIN;
            end else begin
              r_t <= r_t + SW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (r_dcnt == DW'(DRAIN_N - 1)) begin
            r_done         <= 1'b1;
            r_result_valid <= 1'b1;
            r_state        <= S_DONE;
          end else begin
            r_dcnt <= r_dcnt + DW'(1);
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Per-lane skewed masks, decoded only from registered t/K/state.
  for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
    systolic_tile_lane #(.LANE(gr), .KW(KW), .SW(SW)) u_lane (
      .i_feed(w_feed), .i_t(r_t), .i_k(r_k), .o_valid(row_valid_o[gr])
    );
  end
  for (genvar gc = 0; gc < COLS; gc++) begin : g_col
    systolic_tile_lane #(.LANE(gc), .KW(KW), .SW(SW)) u_lane (
      .i_feed(w_feed), .i_t(r_t), .i_k(r_k), .o_valid(col_valid_o[gc])
    );
  end

  assign busy_o         = r_busy;
  assign clear_acc_o    = r_clear;
  assign done_o         = r_done;
  assign result_valid_o = r_result_valid;
  assign step_o         = r_t;
endmodule
